ahb_m2s3_interconnect: RTL and testbench
========================================

Name: ahb_m2s3_interconnect

Overview:
AHB-Lite-style shared-bus interconnect for 2 AHB masters and 3 AHB slaves.
- Contains the arbiter, address/control/write-data multiplexers, address decoder, default slave and read/response multiplexer.
- Sits between master BFMs or CPUs and memory-mapped slaves such as on-chip memories.

Parameters:
P_HSEL0_START, 16'h0000, HADDR[31:16] base of slave 0
P_HSEL0_SIZE, 16'h0100, slave 0 window size in 64 KB units
P_HSEL1_START, 16'h1000, slave 1 base
P_HSEL1_SIZE, 16'h0100, slave 1 size
P_HSEL2_START, 16'h2000, slave 2 base
P_HSEL2_SIZE, 16'h0100, slave 2 size

Ports:
HCLK  in  1  bus clock, all logic on rising edge
HRESETn  in  1  synchronous active-low reset
M_HBUSREQ_0/_1  in  1  master bus request
M_HGRANT_0/_1  out  1  master grant
M_HADDR_0/_1  in  32  master address
M_HTRANS_0/_1  in  2  master transfer type
M_HWRITE_0/_1  in  1  master write
M_HSIZE_0/_1  in  3  master size
M_HBURST_0/_1  in  3  master burst
M_HPROT_0/_1  in  4  master protection
M_HWDATA_0/_1  in  32  master write data
M_HRDATA  out  32  read data to all masters
M_HRESP  out  2  response to all masters
M_HREADY  out  1  transfer done, to all masters
HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT  out  32/2/1/3/3/4  muxed slave-side address/control
HWDATA  out  32  muxed write data
HREADY  out  1  slave HREADYin; equals M_HREADY
HSEL_0/_1/_2  out  1  slave select
HRDATA_0/_1/_2  in  32  slave read data
HRESP_0/_1/_2  in  2  slave response
HREADY_0/_1/_2  in  1  slave HREADYout
REMAP  in  1  swaps slave 0 and slave 1 windows when 1

Behaviour:
- Arbitration:
  - Grant may change only on a cycle with HREADY=1.
  - Default is fixed priority, master 0 over master 1.
  - With no request, the bus parks on master 0.
  - Exactly one M_HGRANT_x is high at all times.
  - Address owner = registered grant, updated when HREADY=1.
- Address phase:
  - HADDR, HTRANS, HWRITE, HSIZE, HBURST and HPROT are combinationally muxed from the address owner.
- Data phase:
  - Data owner = address owner, registered when HREADY=1.
  - HWDATA is muxed from the data owner.
- Decoder:
  - HSEL_i=1 when START_i <= HADDR[31:16] < START_i+SIZE_i (17-bit compare, no wrap).
  - With REMAP=1, the slave 0 and slave 1 windows are swapped.
  - Windows are assumed non-overlapping; lowest index wins on overlap.
  - The decoder is purely combinational on HADDR and is independent of HTRANS.
- Response mux:
  - Data-phase select is registered from the HSEL vector when HREADY=1.
  - M_HRDATA, M_HRESP and M_HREADY come from the selected slave.
  - When no slave is selected, the default slave responds.
- Default slave, address matching no window:
  - IDLE or BUSY transfer: OKAY with zero wait.
  - NONSEQ or SEQ transfer: two-cycle ERROR. Cycle 1 is HREADY=0, HRESP=ERROR(2'b01); cycle 2 is HREADY=1, HRESP=ERROR. Read data is 0.
- Reset values:
  - M_HGRANT_0=1, M_HGRANT_1=0.
  - Owners = master 0.
  - Data-phase select = default slave idle, so M_HREADY=1, M_HRESP=OKAY, M_HRDATA=0.
- Reset mid-transfer: all registers return to reset values on the next edge; pending transfers are dropped.
- Simultaneous requests at a grant point: master 0 wins (unless the optional feature is enabled).
- Burst handling:
  - No early-burst protection: a higher-priority request can re-arbitrate at any HREADY=1 beat.
  - Masters must handle the loss of grant.

Optional Feature:
AHB_ROUND_ROBIN_EN
- Defined: 2-way round-robin arbitration; the last-granted master gets lowest priority at the next arbitration point. Parking stays on the last owner.
- Undefined: fixed priority, master 0 highest, parking on master 0.

Decomposition:
- Shared package ahb_pkg: HTRANS codes (IDLE, BUSY, NONSEQ, SEQ), HRESP codes (OKAY, ERROR, RETRY, SPLIT), HSIZE/HBURST encodings.
- One natural sub-module: ahb_arbiter_m2, containing grant generation and owner registers.
- Decoder, muxes and default slave stay in the top module.

Test Plan:
- Reset: hold HRESETn=0 for 10 cycles -> M_HGRANT_0=1, M_HGRANT_1=0, M_HREADY=1, M_HRESP=2'b00.
- Master 0, slave 1 write/read: write 32'hA5A5_0001 to 0x1000_0010, then read it back -> HSEL_1=1 in the address phase, read returns 32'hA5A5_0001, HRESP OKAY.
- Both masters request together -> master 0 granted first (fixed priority). Master 1 is granted after M_HBUSREQ_0 drops, on an HREADY=1 cycle, and its address 0x2000_0000 asserts HSEL_2.
- Wait states: slave holds HREADY_0=0 for 3 cycles -> M_HREADY low for 3 cycles, and grant and address owner stay unchanged.
- Unmapped NONSEQ read at 0x3000_0000 -> two cycles: HREADY=0/ERROR then HREADY=1/ERROR. An IDLE to the same address gives OKAY.
- REMAP=1 with an access to 0x0000_0004 -> HSEL_1=1, HSEL_0=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the 2-master / 3-slave interconnect.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RespOkay  = 2'b00,
    RespError = 2'b01,
    RespRetry = 2'b10,
    RespSplit = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    SizeByte, SizeHalf, SizeWord, Size64, Size128, Size256, Size512, Size1024
  } hsize_e;

  typedef enum logic [2:0] {
    BurstSingle, BurstIncr, BurstWrap4, BurstIncr4,
    BurstWrap8, BurstIncr8, BurstWrap16, BurstIncr16
  } hburst_e;

  // Data-phase response source.
  typedef enum logic [1:0] {
    SelS0  = 2'b00,
    SelS1  = 2'b01,
    SelS2  = 2'b10,
    SelDef = 2'b11
  } dsel_e;

  // Default slave: two-cycle ERROR sequence for active transfers to unmapped space.
  typedef enum logic [1:0] {
    DsIdle = 2'b00,
    DsErr1 = 2'b01,
    DsErr2 = 2'b10
  } ds_state_e;

  // Window hit on HADDR[31:16]; 17-bit arithmetic so start+size never wraps.
  function automatic logic in_window(logic [15:0] addr_hi, logic [15:0] start,
                                     logic [15:0] size);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = {1'b0, start};
    hi = {1'b0, start} + {1'b0, size};
    return ({1'b0, addr_hi} >= lo) && ({1'b0, addr_hi} < hi);
  endfunction

endpackage

// File: rtl/ahb_arbiter_m2.sv
// Two-master AHB arbiter: grant generation plus address/data owner registers.
// Optional macro AHB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module ahb_arbiter_m2 (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] hbusreq_i,
  input  logic       hready_i,
  output logic [1:0] hgrant_o,
  output logic       addr_owner_o,
  output logic       data_owner_o
);

  logic grant_q, grant_d;
  logic addr_owner_q, data_owner_q;

  // Next grant index, taken only at HREADY=1 points.
  always_comb begin
    grant_d = 1'b0;
`ifdef AHB_ROUND_ROBIN_EN
    if (hbusreq_i[0] && hbusreq_i[1]) begin
      grant_d = ~grant_q;
    end else if (hbusreq_i[0]) begin
      grant_d = 1'b0;
    end else if (hbusreq_i[1]) begin
      grant_d = 1'b1;
    end else begin
      grant_d = grant_q;
    end
`else
    if (hbusreq_i[0]) begin
      grant_d = 1'b0;
    end else if (hbusreq_i[1]) begin
      grant_d = 1'b1;
    end else begin
      grant_d = 1'b0;
    end
`endif
  end

  // Grant -> address owner -> data owner pipeline, advancing on HREADY.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      grant_q      <= 1'b0;
      addr_owner_q <= 1'b0;
      data_owner_q <= 1'b0;
    end else if (hready_i) begin
      grant_q      <= grant_d;
      addr_owner_q <= grant_q;
      data_owner_q <= addr_owner_q;
    end
  end

  assign hgrant_o     = {grant_q, ~grant_q};
  assign addr_owner_o = addr_owner_q;
  assign data_owner_o = data_owner_q;

endmodule

// File: rtl/ahb_m2s3_interconnect.sv
// AHB-Lite shared-bus interconnect, 2 masters x 3 slaves: arbiter, muxes, decoder,
// default slave and response mux. Optional macro AHB_ROUND_ROBIN_EN (see arbiter).
module ahb_m2s3_interconnect
  import ahb_pkg::*;
#(
  parameter logic [15:0] P_HSEL0_START = 16'h0000,
  parameter logic [15:0] P_HSEL0_SIZE  = 16'h0100,
  parameter logic [15:0] P_HSEL1_START = 16'h1000,
  parameter logic [15:0] P_HSEL1_SIZE  = 16'h0100,
  parameter logic [15:0] P_HSEL2_START = 16'h2000,
  parameter logic [15:0] P_HSEL2_SIZE  = 16'h0100
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        M_HBUSREQ_0,
  input  logic        M_HBUSREQ_1,
  output logic        M_HGRANT_0,
  output logic        M_HGRANT_1,
  input  logic [31:0] M_HADDR_0,
  input  logic [31:0] M_HADDR_1,
  input  logic [1:0]  M_HTRANS_0,
  input  logic [1:0]  M_HTRANS_1,
  input  logic        M_HWRITE_0,
  input  logic        M_HWRITE_1,
  input  logic [2:0]  M_HSIZE_0,
  input  logic [2:0]  M_HSIZE_1,
  input  logic [2:0]  M_HBURST_0,
  input  logic [2:0]  M_HBURST_1,
  input  logic [3:0]  M_HPROT_0,
  input  logic [3:0]  M_HPROT_1,
  input  logic [31:0] M_HWDATA_0,
  input  logic [31:0] M_HWDATA_1,
  output logic [31:0] M_HRDATA,
  output logic [1:0]  M_HRESP,
  output logic        M_HREADY,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  output logic        HREADY,
  output logic        HSEL_0,
  output logic        HSEL_1,
  output logic        HSEL_2,
  input  logic [31:0] HRDATA_0,
  input  logic [31:0] HRDATA_1,
  input  logic [31:0] HRDATA_2,
  input  logic [1:0]  HRESP_0,
  input  logic [1:0]  HRESP_1,
  input  logic [1:0]  HRESP_2,
  input  logic        HREADY_0,
  input  logic        HREADY_1,
  input  logic        HREADY_2,
  input  logic        REMAP
);

  logic [1:0] hgrant;
  logic       addr_owner;
  logic       data_owner;
  logic       hready_mux;
  logic [2:0] hsel;
  logic [2:0] hit;
  logic [15:0] win0_start, win0_size, win1_start, win1_size;
  dsel_e      dsel_q, dsel_d;
  ds_state_e  ds_q, ds_d;

  ahb_arbiter_m2 u_arbiter (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .hbusreq_i    ({M_HBUSREQ_1, M_HBUSREQ_0}),
    .hready_i     (hready_mux),
    .hgrant_o     (hgrant),
    .addr_owner_o (addr_owner),
    .data_owner_o (data_owner)
  );

  assign M_HGRANT_0 = hgrant[0];
  assign M_HGRANT_1 = hgrant[1];

  // Address/control mux from the address owner.
  always_comb begin
    HADDR  = M_HADDR_0;
    HTRANS = M_HTRANS_0;
    HWRITE = M_HWRITE_0;
    HSIZE  = M_HSIZE_0;
    HBURST = M_HBURST_0;
    HPROT  = M_HPROT_0;
    if (addr_owner) begin
      HADDR  = M_HADDR_1;
      HTRANS = M_HTRANS_1;
      HWRITE = M_HWRITE_1;
      HSIZE  = M_HSIZE_1;
      HBURST = M_HBURST_1;
      HPROT  = M_HPROT_1;
    end
  end

  assign HWDATA = data_owner ? M_HWDATA_1 : M_HWDATA_0;

  // Address decoder; REMAP swaps the slave 0 and slave 1 windows, lowest index wins.
  always_comb begin
    win0_start = REMAP ? P_HSEL1_START : P_HSEL0_START;
    win0_size  = REMAP ? P_HSEL1_SIZE  : P_HSEL0_SIZE;
    win1_start = REMAP ? P_HSEL0_START : P_HSEL1_START;
    win1_size  = REMAP ? P_HSEL0_SIZE  : P_HSEL1_SIZE;
    hit[0] = in_window(HADDR[31:16], win0_start, win0_size);
    hit[1] = in_window(HADDR[31:16], win1_start, win1_size);
    hit[2] = in_window(HADDR[31:16], P_HSEL2_START, P_HSEL2_SIZE);
    hsel   = 3'b000;
    dsel_d = SelDef;
    if (hit[0]) begin
      hsel   = 3'b001;
      dsel_d = SelS0;
    end else if (hit[1]) begin
      hsel   = 3'b010;
      dsel_d = SelS1;
    end else if (hit[2]) begin
      hsel   = 3'b100;
      dsel_d = SelS2;
    end
  end

  assign HSEL_0 = hsel[0];
  assign HSEL_1 = hsel[1];
  assign HSEL_2 = hsel[2];

  // Default slave next state: arm the error pair on an active transfer to unmapped space.
  always_comb begin
    ds_d = ds_q;
    if (hready_mux) begin
      ds_d = ((hsel == 3'b000) && HTRANS[1]) ? DsErr1 : DsIdle;
    end else if (ds_q == DsErr1) begin
      ds_d = DsErr2;
    end
  end

  // Data-phase select and default slave state registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dsel_q <= SelDef;
      ds_q   <= DsIdle;
    end else begin
      if (hready_mux) begin
        dsel_q <= dsel_d;
      end
      ds_q <= ds_d;
    end
  end

  // Response mux: selected slave or the default slave.
  always_comb begin
    M_HRDATA   = 32'h0;
    M_HRESP    = RespOkay;
    hready_mux = 1'b1;
    unique case (dsel_q)
      SelS0: begin
        M_HRDATA   = HRDATA_0;
        M_HRESP    = HRESP_0;
        hready_mux = HREADY_0;
      end
      SelS1: begin
        M_HRDATA   = HRDATA_1;
        M_HRESP    = HRESP_1;
        hready_mux = HREADY_1;
      end
      SelS2: begin
        M_HRDATA   = HRDATA_2;
        M_HRESP    = HRESP_2;
        hready_mux = HREADY_2;
      end
      SelDef: begin
        hready_mux = (ds_q != DsErr1);
        M_HRESP    = (ds_q == DsIdle) ? RespOkay : RespError;
      end
      default: ;
    endcase
  end

  assign M_HREADY = hready_mux;
  assign HREADY   = hready_mux;

endmodule

// File: tb/tb_ahb_m2s3_interconnect.sv
// Self-checking bench for ahb_m2s3_interconnect: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural bus model.
module tb_ahb_m2s3_interconnect;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        M_HBUSREQ_0, M_HBUSREQ_1;
  logic        M_HGRANT_0, M_HGRANT_1;
  logic [31:0] M_HADDR_0, M_HADDR_1;
  logic [1:0]  M_HTRANS_0, M_HTRANS_1;
  logic        M_HWRITE_0, M_HWRITE_1;
  logic [2:0]  M_HSIZE_0, M_HSIZE_1, M_HBURST_0, M_HBURST_1;
  logic [3:0]  M_HPROT_0, M_HPROT_1;
  logic [31:0] M_HWDATA_0, M_HWDATA_1;
  logic [31:0] M_HRDATA;
  logic [1:0]  M_HRESP;
  logic        M_HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HSEL_0, HSEL_1, HSEL_2;
  logic [31:0] HRDATA_0, HRDATA_1, HRDATA_2;
  logic [1:0]  HRESP_0, HRESP_1, HRESP_2;
  logic        HREADY_0, HREADY_1, HREADY_2;
  logic        REMAP;

  ahb_m2s3_interconnect dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M_HBUSREQ_0(M_HBUSREQ_0), .M_HBUSREQ_1(M_HBUSREQ_1),
    .M_HGRANT_0(M_HGRANT_0), .M_HGRANT_1(M_HGRANT_1),
    .M_HADDR_0(M_HADDR_0), .M_HADDR_1(M_HADDR_1),
    .M_HTRANS_0(M_HTRANS_0), .M_HTRANS_1(M_HTRANS_1),
    .M_HWRITE_0(M_HWRITE_0), .M_HWRITE_1(M_HWRITE_1),
    .M_HSIZE_0(M_HSIZE_0), .M_HSIZE_1(M_HSIZE_1),
    .M_HBURST_0(M_HBURST_0), .M_HBURST_1(M_HBURST_1),
    .M_HPROT_0(M_HPROT_0), .M_HPROT_1(M_HPROT_1),
    .M_HWDATA_0(M_HWDATA_0), .M_HWDATA_1(M_HWDATA_1),
    .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP), .M_HREADY(M_HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
    .HSEL_0(HSEL_0), .HSEL_1(HSEL_1), .HSEL_2(HSEL_2),
    .HRDATA_0(HRDATA_0), .HRDATA_1(HRDATA_1), .HRDATA_2(HRDATA_2),
    .HRESP_0(HRESP_0), .HRESP_1(HRESP_1), .HRESP_2(HRESP_2),
    .HREADY_0(HREADY_0), .HREADY_1(HREADY_1), .HREADY_2(HREADY_2),
    .REMAP(REMAP)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave index hit by an address, 3 meaning unmapped.
  function automatic int target(logic [31:0] a, logic remap);
    int hi;
    int st[3];
    hi = int'(a[31:16]);
    st = '{32'h0000, 32'h1000, 32'h2000};
    if (remap) begin
      st[0] = 32'h1000;
      st[1] = 32'h0000;
    end
    for (int i = 0; i < 3; i++) begin
      if (hi >= st[i] && hi < st[i] + 32'h100) return i;
    end
    return 3;
  endfunction

  // Behavioural model state: who owns which phase, where the data phase goes,
  // and how many default-slave error cycles have elapsed (0 = none pending).
  bit   model_valid = 1'b0;
  int   m_grant, m_aown, m_down, m_dsel, m_err_cyc;
  logic e_hready;
  logic [1:0] e_trans;
  int   e_tgt;

  // Compare every DUT output against the model once per cycle.
  always @(negedge HCLK) begin : cmp
    logic [31:0] ea, ewd, erd;
    logic [1:0]  eresp;
    logic [2:0]  ehsel;
    if (model_valid) begin
      ea      = m_aown ? M_HADDR_1 : M_HADDR_0;
      e_trans = m_aown ? M_HTRANS_1 : M_HTRANS_0;
      ewd     = m_down ? M_HWDATA_1 : M_HWDATA_0;
      e_tgt   = target(ea, REMAP);
      ehsel   = (e_tgt < 3) ? 3'(1 << e_tgt) : 3'b000;
      erd = 32'h0; eresp = 2'b00; e_hready = 1'b1;
      case (m_dsel)
        0: begin erd = HRDATA_0; eresp = HRESP_0; e_hready = HREADY_0; end
        1: begin erd = HRDATA_1; eresp = HRESP_1; e_hready = HREADY_1; end
        2: begin erd = HRDATA_2; eresp = HRESP_2; e_hready = HREADY_2; end
        default: begin
          if (m_err_cyc != 0) eresp = 2'b01;
          e_hready = (m_err_cyc != 1);
        end
      endcase
      check("m_hgrant", {M_HGRANT_1, M_HGRANT_0}, (m_grant == 1) ? 2'b10 : 2'b01);
      check("haddr", HADDR, ea);
      check("htrans", HTRANS, e_trans);
      check("hwrite", HWRITE, m_aown ? M_HWRITE_1 : M_HWRITE_0);
      check("hsize", HSIZE, m_aown ? M_HSIZE_1 : M_HSIZE_0);
      check("hburst", HBURST, m_aown ? M_HBURST_1 : M_HBURST_0);
      check("hprot", HPROT, m_aown ? M_HPROT_1 : M_HPROT_0);
      check("hwdata", HWDATA, ewd);
      check("hsel", {HSEL_2, HSEL_1, HSEL_0}, ehsel);
      check("m_hrdata", M_HRDATA, erd);
      check("m_hresp", M_HRESP, eresp);
      check("m_hready", M_HREADY, e_hready);
      check("hready", HREADY, e_hready);
    end
  end

  // Advance the model on each clock edge.
  always @(posedge HCLK) begin
    if (!HRESETn) begin
      m_grant <= 0; m_aown <= 0; m_down <= 0; m_dsel <= 3; m_err_cyc <= 0;
      model_valid <= 1'b1;
    end else if (model_valid && e_hready) begin
`ifdef AHB_ROUND_ROBIN_EN
      if (M_HBUSREQ_0 && M_HBUSREQ_1) m_grant <= 1 - m_grant;
      else if (M_HBUSREQ_0) m_grant <= 0;
      else if (M_HBUSREQ_1) m_grant <= 1;
`else
      m_grant <= (!M_HBUSREQ_0 && M_HBUSREQ_1) ? 1 : 0;
`endif
      m_aown    <= m_grant;
      m_down    <= m_aown;
      m_dsel    <= e_tgt;
      m_err_cyc <= (e_tgt == 3 && e_trans[1]) ? 1 : 0;
    end else if (model_valid && m_err_cyc == 1) begin
      m_err_cyc <= 2;
    end
  end

  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  task automatic at_neg();
    @(negedge HCLK);
    #1;
  endtask

  logic [31:0] mem1;
  logic [31:0] addr_tbl [10];

  initial begin
    addr_tbl = '{32'h0000_0000, 32'h00FF_FFFC, 32'h0100_0000, 32'h1000_0010, 32'h10FF_FFFC,
                 32'h1100_0000, 32'h2000_0000, 32'h20FF_FFFC, 32'h3000_0000, 32'hFFFF_FFFC};
    HRESETn = 1'b0; REMAP = 1'b0;
    M_HBUSREQ_0 = 0; M_HBUSREQ_1 = 0;
    M_HADDR_0 = '0; M_HADDR_1 = '0; M_HTRANS_0 = '0; M_HTRANS_1 = '0;
    M_HWRITE_0 = 0; M_HWRITE_1 = 0; M_HSIZE_0 = 3'd2; M_HSIZE_1 = 3'd2;
    M_HBURST_0 = '0; M_HBURST_1 = '0; M_HPROT_0 = 4'h3; M_HPROT_1 = 4'h3;
    M_HWDATA_0 = '0; M_HWDATA_1 = '0;
    HRDATA_0 = '0; HRDATA_1 = '0; HRDATA_2 = '0;
    HRESP_0 = '0; HRESP_1 = '0; HRESP_2 = '0;
    HREADY_0 = 1; HREADY_1 = 1; HREADY_2 = 1;

    repeat (10) step();
    at_neg();
    check("rst_grant0", M_HGRANT_0, 1);
    check("rst_grant1", M_HGRANT_1, 0);
    check("rst_hready", M_HREADY, 1);
    check("rst_hresp", M_HRESP, 2'b00);
    check("rst_hrdata", M_HRDATA, 32'h0);

    // Master 0 write then read to slave 1.
    step(); HRESETn = 1;
    M_HBUSREQ_0 = 1; M_HADDR_0 = 32'h1000_0010; M_HTRANS_0 = 2'b10; M_HWRITE_0 = 1;
    at_neg(); check("wr_hsel1", HSEL_1, 1); check("wr_haddr", HADDR, 32'h1000_0010);
    step(); M_HTRANS_0 = 2'b00; M_HWRITE_0 = 0; M_HWDATA_0 = 32'hA5A5_0001;
    at_neg(); check("wr_hwdata", HWDATA, 32'hA5A5_0001); mem1 = HWDATA;
    step(); M_HTRANS_0 = 2'b10;
    at_neg(); check("rd_hsel1", HSEL_1, 1); check("rd_hwrite", HWRITE, 0);
    step(); M_HTRANS_0 = 2'b00; HRDATA_1 = mem1;
    at_neg(); check("rd_data", M_HRDATA, 32'hA5A5_0001); check("rd_resp", M_HRESP, 2'b00);

    // Both masters request; master 0 keeps the bus until it drops its request.
    step(); M_HBUSREQ_1 = 1; M_HADDR_1 = 32'h2000_0000; M_HTRANS_1 = 2'b10;
    M_HWRITE_1 = 1; M_HWDATA_1 = 32'h1234_5678;
    step(); at_neg(); check("prio_grant0", {M_HGRANT_1, M_HGRANT_0}, 2'b01);
    step(); M_HBUSREQ_0 = 0;
    at_neg(); check("prio_hold0", {M_HGRANT_1, M_HGRANT_0}, 2'b01);
    step(); at_neg(); check("grant_m1", {M_HGRANT_1, M_HGRANT_0}, 2'b10);
    step(); at_neg(); check("m1_haddr", HADDR, 32'h2000_0000); check("m1_hsel2", HSEL_2, 1);
    step(); M_HTRANS_1 = 2'b00;
    at_neg(); check("m1_hwdata", HWDATA, 32'h1234_5678);

    // Slave 0 holds HREADY low for 3 cycles; grant and owner must not move.
    step(); M_HADDR_1 = 32'h0000_0040; M_HTRANS_1 = 2'b10; M_HWRITE_1 = 0;
    M_HADDR_0 = 32'h2000_0100;
    at_neg(); check("ws_hsel0", HSEL_0, 1);
    step(); M_HTRANS_1 = 2'b00; HREADY_0 = 0; M_HBUSREQ_0 = 1; HRDATA_0 = 32'hCAFE_0040;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("ws_hready_low", M_HREADY, 0);
      check("ws_grant_hold", {M_HGRANT_1, M_HGRANT_0}, 2'b10);
      check("ws_owner_hold", HADDR, 32'h0000_0040);
      step();
    end
    HREADY_0 = 1;
    at_neg(); check("ws_done", M_HREADY, 1); check("ws_rdata", M_HRDATA, 32'hCAFE_0040);
    step(); at_neg(); check("regrant_m0", {M_HGRANT_1, M_HGRANT_0}, 2'b01);

    // Unmapped NONSEQ read then IDLE to the same address.
    step(); M_HADDR_0 = 32'h3000_0000; M_HTRANS_0 = 2'b10; M_HWRITE_0 = 0;
    at_neg(); check("um_hsel", {HSEL_2, HSEL_1, HSEL_0}, 3'b000);
    step(); M_HTRANS_0 = 2'b00;
    at_neg(); check("um_c1_ready", M_HREADY, 0); check("um_c1_resp", M_HRESP, 2'b01);
    check("um_c1_rdata", M_HRDATA, 32'h0);
    step(); at_neg(); check("um_c2_ready", M_HREADY, 1); check("um_c2_resp", M_HRESP, 2'b01);
    step(); at_neg(); check("um_idle_resp", M_HRESP, 2'b00); check("um_idle_ready", M_HREADY, 1);

    // REMAP and window boundaries.
    step(); REMAP = 1; M_HADDR_0 = 32'h0000_0004; M_HTRANS_0 = 2'b10;
    at_neg(); check("remap_sel", {HSEL_2, HSEL_1, HSEL_0}, 3'b010);
    step(); REMAP = 0; M_HTRANS_0 = 2'b00; M_HADDR_0 = 32'h00FF_FFFC;
    at_neg(); check("edge_top_s0", {HSEL_2, HSEL_1, HSEL_0}, 3'b001);
    step(); M_HADDR_0 = 32'h0100_0000;
    at_neg(); check("edge_past_s0", {HSEL_2, HSEL_1, HSEL_0}, 3'b000);

    // Randomized traffic, including occasional mid-transfer reset and REMAP flips.
    for (int n = 0; n < 3000; n++) begin
      step();
      HRESETn     = ($urandom_range(0, 299) != 0);
      M_HBUSREQ_0 = $urandom_range(0, 2) == 0;
      M_HBUSREQ_1 = $urandom_range(0, 1) == 0;
      M_HADDR_0   = addr_tbl[$urandom_range(0, 9)] ^ {28'h0, 4'($urandom_range(0, 3) << 2)};
      M_HADDR_1   = addr_tbl[$urandom_range(0, 9)] ^ {28'h0, 4'($urandom_range(0, 3) << 2)};
      M_HTRANS_0  = 2'($urandom); M_HTRANS_1 = 2'($urandom);
      M_HWRITE_0  = 1'($urandom); M_HWRITE_1 = 1'($urandom);
      M_HSIZE_0   = 3'($urandom); M_HSIZE_1  = 3'($urandom);
      M_HBURST_0  = 3'($urandom); M_HBURST_1 = 3'($urandom);
      M_HPROT_0   = 4'($urandom); M_HPROT_1  = 4'($urandom);
      M_HWDATA_0  = $urandom; M_HWDATA_1 = $urandom;
      HRDATA_0 = $urandom; HRDATA_1 = $urandom; HRDATA_2 = $urandom;
      HRESP_0  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      HRESP_1  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      HRESP_2  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      HREADY_0 = $urandom_range(0, 3) != 0;
      HREADY_1 = $urandom_range(0, 3) != 0;
      HREADY_2 = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 49) == 0) REMAP = ~REMAP;
    end
    step();
    HRESETn = 1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
